mem_arbiter: RTL and testbench

- Shares one single-port, multi-cycle unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw/call/ret data access).
- Strict data priority. Sequences each access for LAT cycles and returns read data.
- Generates stall_if/stall_mem so the pipeline freezes while its access is pending.
- Supports aborting an in-flight fetch on a branch/call flush.

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 92 +++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: pipeline request/response and memory-side signals of the arbiter
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_abort;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          stall_if;
    logic          stall_mem;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_abort, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rdata, d_ready, d_rdata, stall_if, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, if_abort, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata, stall_if, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: data-priority sharing of one multi-cycle memory between fetch and data access
module mem_arbiter #(
    parameter int LAT = 4,
    parameter int AW  = 16,
    parameter int DW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int             CW   = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_if_hold;
    logic [DW-1:0] r_d_hold;
    logic          w_last;
    logic          w_grant_d;
    logic          w_grant_i;

    // Arbitration, completion decode and memory/pipeline outputs
    always_comb begin
        w_next       = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        w_last       = (r_cnt == LAST);
        bus.if_ready = 1'b0;
        bus.d_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.d_req) begin
                    w_grant_d = 1'b1;
                    w_next    = BUSY_D;
                end else if (bus.if_req && !bus.if_abort) begin
                    w_grant_i = 1'b1;
                    w_next    = BUSY_I;
                end
            end
            BUSY_D: begin
                bus.d_ready = w_last;
                w_next      = w_last ? IDLE : BUSY_D;
            end
            BUSY_I: begin
                bus.if_ready = w_last && !bus.if_abort;
                w_next       = (w_last || bus.if_abort) ? IDLE : BUSY_I;
            end
            default: w_next = IDLE;
        endcase
        bus.mem_en    = (r_state != IDLE);
        bus.mem_we    = bus.mem_en && r_we;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        bus.if_rdata  = bus.if_ready ? bus.mem_rdata : r_if_hold;
        bus.d_rdata   = (bus.d_ready && !r_we) ? bus.mem_rdata : r_d_hold;
        bus.stall_mem = bus.d_req && !bus.d_ready;
        bus.stall_if  = (bus.if_req && !bus.if_ready && !bus.if_abort) || bus.stall_mem;
    end

    // State, beat counter, latched request and read-data hold registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_if_hold <= '0;
            r_d_hold  <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state != IDLE && w_next == r_state) ? r_cnt + 1'b1 : '0;
            if (w_grant_d) begin
                r_addr  <= bus.d_addr;
                r_we    <= bus.d_we;
                r_wdata <= bus.d_wdata;
            end else if (w_grant_i) begin
                r_addr <= bus.if_addr;
                r_we   <= 1'b0;
            end
            if (bus.if_ready)
                r_if_hold <= bus.mem_rdata;
            if (bus.d_ready && !r_we)
                r_d_hold <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of the arbiter at LAT=4 and LAT=1
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_arbiter_if #(.AW(16), .DW(16)) b4 ();
    mem_arbiter_if #(.AW(16), .DW(16)) b1 ();

    mem_arbiter #(.LAT(4), .AW(16), .DW(16)) u4 (.clk(clk), .rst(rst), .bus(b4));
    mem_arbiter #(.LAT(1), .AW(16), .DW(16)) u1 (.clk(clk), .rst(rst), .bus(b1));

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [15:0] mdl(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hB123;
            16'h0020: return 16'h7E20;
            16'h0040: return 16'h4040;
            16'h8000: return 16'h5A5A;
            default:  return a ^ 16'hA5A5;
        endcase
    endfunction

    // Memory read models for both instances
    always_comb b4.mem_rdata = mdl(b4.mem_addr);
    always_comb b1.mem_rdata = mdl(b1.mem_addr);

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        b4.if_req = 0; b4.if_addr = 0; b4.if_abort = 0; b4.d_req = 0; b4.d_we = 0; b4.d_addr = 0; b4.d_wdata = 0;
        b1.if_req = 0; b1.if_addr = 0; b1.if_abort = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
    endtask

    task automatic test_reset;
        idle_all();
        rst = 0;
        b4.if_req = 1; b4.if_addr = 16'h0010;
        cyc(); cyc(); #1;
        n_cmp++; if (b4.mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en: got %b want 0", b4.mem_en); end
        n_cmp++; if (b4.mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %b want 0", b4.mem_we); end
        n_cmp++; if (b4.if_ready !== 1'b0) begin n_err++; $display("FAIL reset_if_ready: got %b want 0", b4.if_ready); end
        n_cmp++; if (b4.d_ready !== 1'b0) begin n_err++; $display("FAIL reset_d_ready: got %b want 0", b4.d_ready); end
        n_cmp++; if (b4.mem_addr !== 16'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0000", b4.mem_addr); end
        n_cmp++; if (b4.mem_wdata !== 16'h0) begin n_err++; $display("FAIL reset_mem_wdata: got %h want 0000", b4.mem_wdata); end
        n_cmp++; if (b4.if_rdata !== 16'h0) begin n_err++; $display("FAIL reset_if_rdata: got %h want 0000", b4.if_rdata); end
        n_cmp++; if (b4.d_rdata !== 16'h0) begin n_err++; $display("FAIL reset_d_rdata: got %h want 0000", b4.d_rdata); end
        n_cmp++; if (b4.stall_if !== 1'b1) begin n_err++; $display("FAIL reset_stall_if: got %b want 1", b4.stall_if); end
        n_cmp++; if (b4.stall_mem !== 1'b0) begin n_err++; $display("FAIL reset_stall_mem: got %b want 0", b4.stall_mem); end
        n_cmp++; if (b1.mem_en !== 1'b0) begin n_err++; $display("FAIL reset_lat1_mem_en: got %b want 0", b1.mem_en); end
        rst = 1;
        b4.if_req = 0;
    endtask

    task automatic test_fetch;
        cyc();
        b4.if_req = 1; b4.if_addr = 16'h0010; #1;
        n_cmp++; if (b4.stall_if !== 1'b1) begin n_err++; $display("FAIL fetch_stall_c0: got %b want 1", b4.stall_if); end
        n_cmp++; if (b4.mem_en !== 1'b0) begin n_err++; $display("FAIL fetch_mem_en_c0: got %b want 0", b4.mem_en); end
        for (int k = 1; k <= 4; k++) begin
            cyc(); #1;
            n_cmp++; if (b4.mem_en !== 1'b1) begin n_err++; $display("FAIL fetch_mem_en_c%0d: got %b want 1", k, b4.mem_en); end
            n_cmp++; if (b4.if_ready !== (k == 4)) begin n_err++; $display("FAIL fetch_if_ready_c%0d: got %b want %b", k, b4.if_ready, k == 4); end
            n_cmp++; if (b4.stall_if !== (k != 4)) begin n_err++; $display("FAIL fetch_stall_c%0d: got %b want %b", k, b4.stall_if, k != 4); end
            n_cmp++; if (b4.mem_addr !== 16'h0010) begin n_err++; $display("FAIL fetch_mem_addr_c%0d: got %h want 0010", k, b4.mem_addr); end
        end
        n_cmp++; if (b4.if_rdata !== 16'hB123) begin n_err++; $display("FAIL fetch_rdata: got %h want b123", b4.if_rdata); end
        cyc();
        b4.if_req = 0; #1;
        n_cmp++; if (b4.mem_en !== 1'b0) begin n_err++; $display("FAIL fetch_idle_mem_en: got %b want 0", b4.mem_en); end
        n_cmp++; if (b4.if_rdata !== 16'hB123) begin n_err++; $display("FAIL fetch_hold: got %h want b123", b4.if_rdata); end
    endtask

    task automatic test_priority;
        cyc();
        b4.if_req = 1; b4.if_addr = 16'h0020; b4.d_req = 1; b4.d_we = 0; b4.d_addr = 16'h8000; #1;
        n_cmp++; if (b4.stall_mem !== 1'b1) begin n_err++; $display("FAIL prio_stall_mem_c0: got %b want 1", b4.stall_mem); end
        for (int k = 1; k <= 4; k++) begin
            cyc(); #1;
            n_cmp++; if (b4.mem_addr !== 16'h8000) begin n_err++; $display("FAIL prio_d_addr_c%0d: got %h want 8000", k, b4.mem_addr); end
            n_cmp++; if (b4.d_ready !== (k == 4)) begin n_err++; $display("FAIL prio_d_ready_c%0d: got %b want %b", k, b4.d_ready, k == 4); end
            n_cmp++; if (b4.if_ready !== 1'b0) begin n_err++; $display("FAIL prio_if_ready_c%0d: got %b want 0", k, b4.if_ready); end
            n_cmp++; if (b4.stall_if !== 1'b1) begin n_err++; $display("FAIL prio_stall_if_c%0d: got %b want 1", k, b4.stall_if); end
            n_cmp++; if (b4.stall_mem !== (k != 4)) begin n_err++; $display("FAIL prio_stall_mem_c%0d: got %b want %b", k, b4.stall_mem, k != 4); end
        end
        n_cmp++; if (b4.d_rdata !== 16'h5A5A) begin n_err++; $display("FAIL prio_d_rdata: got %h want 5a5a", b4.d_rdata); end
        cyc();
        b4.d_req = 0; #1;
        n_cmp++; if (b4.mem_en !== 1'b0) begin n_err++; $display("FAIL prio_gap_mem_en: got %b want 0", b4.mem_en); end
        n_cmp++; if (b4.stall_if !== 1'b1) begin n_err++; $display("FAIL prio_gap_stall_if: got %b want 1", b4.stall_if); end
        for (int k = 6; k <= 9; k++) begin
            cyc(); #1;
            n_cmp++; if (b4.mem_addr !== 16'h0020) begin n_err++; $display("FAIL prio_i_addr_c%0d: got %h want 0020", k, b4.mem_addr); end
            n_cmp++; if (b4.if_ready !== (k == 9)) begin n_err++; $display("FAIL prio_if_ready_c%0d: got %b want %b", k, b4.if_ready, k == 9); end
            n_cmp++; if (b4.stall_if !== (k != 9)) begin n_err++; $display("FAIL prio_stall_if_c%0d: got %b want %b", k, b4.stall_if, k != 9); end
        end
        n_cmp++; if (b4.if_rdata !== 16'h7E20) begin n_err++; $display("FAIL prio_if_rdata: got %h want 7e20", b4.if_rdata); end
        n_cmp++; if (b4.d_rdata !== 16'h5A5A) begin n_err++; $display("FAIL prio_d_hold: got %h want 5a5a", b4.d_rdata); end
        cyc();
        b4.if_req = 0;
    endtask

    task automatic test_store;
        cyc();
        b4.d_req = 1; b4.d_we = 1; b4.d_addr = 16'h00F0; b4.d_wdata = 16'hCAFE; #1;
        for (int k = 1; k <= 4; k++) begin
            cyc(); #1;
            n_cmp++; if (b4.mem_we !== 1'b1) begin n_err++; $display("FAIL store_mem_we_c%0d: got %b want 1", k, b4.mem_we); end
            n_cmp++; if (b4.mem_wdata !== 16'hCAFE) begin n_err++; $display("FAIL store_wdata_c%0d: got %h want cafe", k, b4.mem_wdata); end
            n_cmp++; if (b4.mem_addr !== 16'h00F0) begin n_err++; $display("FAIL store_addr_c%0d: got %h want 00f0", k, b4.mem_addr); end
            n_cmp++; if (b4.d_ready !== (k == 4)) begin n_err++; $display("FAIL store_d_ready_c%0d: got %b want %b", k, b4.d_ready, k == 4); end
            n_cmp++; if (b4.d_rdata !== 16'h5A5A) begin n_err++; $display("FAIL store_d_rdata_c%0d: got %h want 5a5a", k, b4.d_rdata); end
        end
        cyc();
        b4.d_req = 0; b4.d_we = 0; #1;
        n_cmp++; if (b4.mem_we !== 1'b0) begin n_err++; $display("FAIL store_idle_mem_we: got %b want 0", b4.mem_we); end
        n_cmp++; if (b4.d_rdata !== 16'h5A5A) begin n_err++; $display("FAIL store_idle_d_rdata: got %h want 5a5a", b4.d_rdata); end
    endtask

    task automatic test_abort;
        cyc();
        b4.if_req = 1; b4.if_addr = 16'h0030; #1;
        cyc(); #1;
        n_cmp++; if (b4.mem_en !== 1'b1) begin n_err++; $display("FAIL abort_mem_en_c1: got %b want 1", b4.mem_en); end
        cyc();
        b4.if_abort = 1; #1;
        n_cmp++; if (b4.if_ready !== 1'b0) begin n_err++; $display("FAIL abort_if_ready_c2: got %b want 0", b4.if_ready); end
        n_cmp++; if (b4.stall_if !== 1'b0) begin n_err++; $display("FAIL abort_stall_if_c2: got %b want 0", b4.stall_if); end
        cyc();
        b4.if_abort = 0; b4.if_addr = 16'h0040; #1;
        n_cmp++; if (b4.mem_en !== 1'b0) begin n_err++; $display("FAIL abort_idle_mem_en_c3: got %b want 0", b4.mem_en); end
        n_cmp++; if (b4.if_rdata !== 16'h7E20) begin n_err++; $display("FAIL abort_if_rdata_c3: got %h want 7e20", b4.if_rdata); end
        n_cmp++; if (b4.stall_if !== 1'b1) begin n_err++; $display("FAIL abort_stall_if_c3: got %b want 1", b4.stall_if); end
        for (int k = 4; k <= 7; k++) begin
            cyc(); #1;
            n_cmp++; if (b4.mem_addr !== 16'h0040) begin n_err++; $display("FAIL abort_new_addr_c%0d: got %h want 0040", k, b4.mem_addr); end
            n_cmp++; if (b4.if_ready !== (k == 7)) begin n_err++; $display("FAIL abort_new_ready_c%0d: got %b want %b", k, b4.if_ready, k == 7); end
        end
        n_cmp++; if (b4.if_rdata !== 16'h4040) begin n_err++; $display("FAIL abort_new_rdata: got %h want 4040", b4.if_rdata); end
        cyc();
        b4.if_req = 0;
    endtask

    task automatic test_reset_mid_write;
        cyc();
        b4.d_req = 1; b4.d_we = 1; b4.d_addr = 16'h00F0; b4.d_wdata = 16'h1234; #1;
        cyc(); #1;
        n_cmp++; if (b4.mem_we !== 1'b1) begin n_err++; $display("FAIL rstw_mem_we_c1: got %b want 1", b4.mem_we); end
        cyc();
        rst = 0; #1;
        n_cmp++; if (b4.d_ready !== 1'b0) begin n_err++; $display("FAIL rstw_d_ready_c2: got %b want 0", b4.d_ready); end
        n_cmp++; if (b4.stall_mem !== 1'b1) begin n_err++; $display("FAIL rstw_stall_mem_c2: got %b want 1", b4.stall_mem); end
        cyc();
        rst = 1; b4.d_req = 0; b4.d_we = 0; #1;
        n_cmp++; if (b4.mem_en !== 1'b0) begin n_err++; $display("FAIL rstw_mem_en: got %b want 0", b4.mem_en); end
        n_cmp++; if (b4.mem_we !== 1'b0) begin n_err++; $display("FAIL rstw_mem_we: got %b want 0", b4.mem_we); end
        n_cmp++; if (b4.if_ready !== 1'b0) begin n_err++; $display("FAIL rstw_if_ready: got %b want 0", b4.if_ready); end
        n_cmp++; if (b4.mem_addr !== 16'h0) begin n_err++; $display("FAIL rstw_mem_addr: got %h want 0000", b4.mem_addr); end
        n_cmp++; if (b4.mem_wdata !== 16'h0) begin n_err++; $display("FAIL rstw_mem_wdata: got %h want 0000", b4.mem_wdata); end
        n_cmp++; if (b4.if_rdata !== 16'h0) begin n_err++; $display("FAIL rstw_if_rdata: got %h want 0000", b4.if_rdata); end
        n_cmp++; if (b4.d_rdata !== 16'h0) begin n_err++; $display("FAIL rstw_d_rdata: got %h want 0000", b4.d_rdata); end
        for (int k = 3; k <= 8; k++) begin
            n_cmp++; if (b4.d_ready !== 1'b0) begin n_err++; $display("FAIL rstw_no_ready_c%0d: got %b want 0", k, b4.d_ready); end
            cyc(); #1;
        end
    endtask

    task automatic test_lat1_stream;
        cyc();
        b1.if_req = 1; b1.if_addr = 16'h0010;
        for (int g = 0; g < 6; g++) begin
            b1.d_req = (g % 2 == 0);
            b1.d_we = (g % 4 == 2);
            b1.d_addr = (g % 4 == 2) ? 16'h00F0 : 16'h8000;
            b1.d_wdata = 16'h1000 + 16'(g);
            #1;
            n_cmp++; if (b1.mem_en !== 1'b0) begin n_err++; $display("FAIL lat1_idle_mem_en_g%0d: got %b want 0", g, b1.mem_en); end
            n_cmp++; if (b1.stall_if !== 1'b1) begin n_err++; $display("FAIL lat1_idle_stall_if_g%0d: got %b want 1", g, b1.stall_if); end
            cyc(); #1;
            n_cmp++; if (b1.mem_en !== 1'b1) begin n_err++; $display("FAIL lat1_busy_mem_en_g%0d: got %b want 1", g, b1.mem_en); end
            n_cmp++; if (b1.d_ready !== (g % 2 == 0)) begin n_err++; $display("FAIL lat1_d_ready_g%0d: got %b want %b", g, b1.d_ready, g % 2 == 0); end
            n_cmp++; if (b1.if_ready !== (g % 2 == 1)) begin n_err++; $display("FAIL lat1_if_ready_g%0d: got %b want %b", g, b1.if_ready, g % 2 == 1); end
            n_cmp++; if (b1.mem_we !== (g % 4 == 2)) begin n_err++; $display("FAIL lat1_mem_we_g%0d: got %b want %b", g, b1.mem_we, g % 4 == 2); end
            n_cmp++; if (b1.mem_addr !== ((g % 2 == 1) ? 16'h0010 : b1.d_addr)) begin n_err++; $display("FAIL lat1_mem_addr_g%0d: got %h want %h", g, b1.mem_addr, (g % 2 == 1) ? 16'h0010 : b1.d_addr); end
            n_cmp++; if (b1.d_rdata !== 16'h5A5A) begin n_err++; $display("FAIL lat1_d_rdata_g%0d: got %h want 5a5a", g, b1.d_rdata); end
            n_cmp++; if (b1.if_rdata !== ((g >= 1) ? 16'hB123 : 16'h0)) begin n_err++; $display("FAIL lat1_if_rdata_g%0d: got %h want %h", g, b1.if_rdata, (g >= 1) ? 16'hB123 : 16'h0); end
            cyc();
        end
        b1.if_req = 0; b1.d_req = 0; b1.d_we = 0;
    endtask

    // Directed test sequence
    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_abort();
        test_reset_mid_write();
        test_lat1_stream();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
